// File: rtl/geofence_pkg.sv
// geofence_pkg: shared point record, feeder FSM states and width helper
package geofence_pkg;
    localparam int NUM_PTS = 6;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [10:0] r;
    } point_t;

    typedef enum logic [2:0] {
        ST_IDLE, ST_PRIME, ST_LOAD, ST_SEND, ST_WAIT, ST_WRITE, ST_DONE
    } feeder_state_e;

    // counter width that never collapses to zero bits when n==1
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/geofence_addr_gen.sv
// geofence_addr_gen: object/point counters and point memory address
module geofence_addr_gen
    import geofence_pkg::*;
#(
    parameter int NUM_OBJ = 50
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clr_i,
    input  logic                             pt_inc_i,
    input  logic                             obj_inc_i,
    output logic [cw(NUM_OBJ*NUM_PTS)-1:0]   mem_addr_o,
    output logic [cw(NUM_OBJ)-1:0]           obj_o,
    output logic                             last_pt_o,
    output logic                             last_obj_o
);
    localparam int AW = cw(NUM_OBJ * NUM_PTS);
    localparam int OW = cw(NUM_OBJ);
    localparam int KW = cw(NUM_PTS);

    logic [OW-1:0] obj_q, obj_d;
    logic [KW-1:0] k_q, k_d;

    assign last_pt_o  = k_q == KW'(NUM_PTS - 1);
    assign last_obj_o = obj_q == OW'(NUM_OBJ - 1);
    assign obj_o      = obj_q;
    assign mem_addr_o = AW'(obj_q) * AW'(NUM_PTS) + AW'(k_q);

    always_comb begin
        obj_d = clr_i ? '0 : (obj_inc_i && !last_obj_o) ? obj_q + 1'b1 : obj_q;
        k_d   = (clr_i || obj_inc_i) ? '0 : pt_inc_i ? k_q + 1'b1 : k_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            obj_q <= '0;
            k_q   <= '0;
        end else begin
            obj_q <= obj_d;
            k_q   <= k_d;
        end
    end
endmodule

// File: rtl/geofence_feeder.sv
// geofence_feeder: streams object points to the geofence receiver and records its verdicts
module geofence_feeder
    import geofence_pkg::*;
#(
    parameter int NUM_OBJ = 50,
    parameter int TIMEOUT = 1023
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    output logic [cw(NUM_OBJ*NUM_PTS)-1:0] mem_addr,
    input  logic [30:0]                    mem_rdata,
    output logic [9:0]                     X,
    output logic [9:0]                     Y,
    output logic [10:0]                    R,
    input  logic                           valid,
    input  logic                           is_inside,
    output logic                           res_we,
    output logic [cw(NUM_OBJ)-1:0]         res_addr,
    output logic                           res_data,
    output logic                           busy,
    output logic                           done,
    output logic                           timeout_err,
    output logic                           proto_err
);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int SW = cw(NUM_PTS);
    localparam int OW = cw(NUM_OBJ);

    feeder_state_e state_q, state_d;
    point_t        pt_q, pt_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [SW-1:0] snd_q, snd_d;
    logic          cap_q, cap_d, tmo_q, tmo_d, perr_q, perr_d;
    logic [OW-1:0] obj;
    logic          last_pt, last_obj, accept, timed_out, pt_inc;

    geofence_addr_gen #(.NUM_OBJ(NUM_OBJ)) u_addr (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (accept),
        .pt_inc_i   (pt_inc),
        .obj_inc_i  (state_q == ST_WRITE),
        .mem_addr_o (mem_addr),
        .obj_o      (obj),
        .last_pt_o  (last_pt),
        .last_obj_o (last_obj)
    );

    assign accept    = (state_q == ST_IDLE) && start;
    assign timed_out = wcnt_q == WW'(TIMEOUT - 1);
    // address leads the registered point by one, so it starts in PRIME and parks on the last point
    assign pt_inc    = (state_q inside {ST_PRIME, ST_LOAD, ST_SEND}) && !last_pt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = start ? ST_PRIME : ST_IDLE;
            ST_PRIME: state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_SEND;
            ST_SEND:  state_d = (snd_q == SW'(NUM_PTS - 1)) ? ST_WAIT : ST_SEND;
            ST_WAIT:  state_d = (valid || timed_out) ? ST_WRITE : ST_WAIT;
            ST_WRITE: state_d = last_obj ? ST_DONE : ST_PRIME;
            default:  state_d = ST_IDLE;
        endcase
        snd_d  = (state_q == ST_SEND) ? snd_q + 1'b1 : '0;
        wcnt_d = (state_q != ST_WAIT) ? '0 : &wcnt_q ? wcnt_q : wcnt_q + 1'b1;
        pt_d   = (state_d == ST_SEND) ? point_t'(mem_rdata) : '0;
        cap_d  = (state_q == ST_WAIT) ? (valid & is_inside) : cap_q;
        tmo_d  = accept ? 1'b0 : tmo_q | ((state_q == ST_WAIT) && timed_out && !valid);
        perr_d = accept ? 1'b0 : perr_q | (valid && (state_q != ST_WAIT));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pt_q    <= '0;
            wcnt_q  <= '0;
            snd_q   <= '0;
            cap_q   <= 1'b0;
            tmo_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pt_q    <= pt_d;
            wcnt_q  <= wcnt_d;
            snd_q   <= snd_d;
            cap_q   <= cap_d;
            tmo_q   <= tmo_d;
            perr_q  <= perr_d;
        end
    end

    assign X           = pt_q.x;
    assign Y           = pt_q.y;
    assign R           = pt_q.r;
    assign res_we      = state_q == ST_WRITE;
    assign res_addr    = res_we ? obj : '0;
    assign res_data    = res_we & cap_q;
    assign busy        = state_q != ST_IDLE;
    assign done        = state_q == ST_DONE;
    assign timeout_err = tmo_q;
    assign proto_err   = perr_q;
endmodule

// File: tb/tb_geofence_feeder.sv
// tb_geofence_feeder: scoreboard bench for the point feeder (3-object and 1-object builds)
module tb_geofence_feeder;
    import geofence_pkg::*;

    logic clk = 0;
    logic reset = 1;
    always #5 clk = ~clk;

    logic        start_a = 0, valid_a = 0, ins_a = 0;
    logic [4:0]  addr_a;
    logic [30:0] rd_a;
    logic [9:0]  x_a, y_a;
    logic [10:0] r_a;
    logic        we_a, rdat_a, busy_a, done_a, terr_a, perr_a;
    logic [1:0]  ra_a;

    logic        start_b = 0, valid_b = 0, ins_b = 0;
    logic [2:0]  addr_b;
    logic [30:0] rd_b;
    logic [9:0]  x_b, y_b;
    logic [10:0] r_b;
    logic        we_b, rdat_b, busy_b, done_b, terr_b, perr_b;
    logic [0:0]  ra_b;

    logic [30:0] mem_a [18];
    logic [30:0] mem_b [6];
    always @(posedge clk) begin
        rd_a <= mem_a[addr_a];
        rd_b <= mem_b[addr_b];
    end

    geofence_feeder #(.NUM_OBJ(3), .TIMEOUT(8)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .mem_addr(addr_a), .mem_rdata(rd_a),
        .X(x_a), .Y(y_a), .R(r_a), .valid(valid_a), .is_inside(ins_a),
        .res_we(we_a), .res_addr(ra_a), .res_data(rdat_a), .busy(busy_a), .done(done_a),
        .timeout_err(terr_a), .proto_err(perr_a)
    );

    geofence_feeder #(.NUM_OBJ(1), .TIMEOUT(8)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .mem_addr(addr_b), .mem_rdata(rd_b),
        .X(x_b), .Y(y_b), .R(r_b), .valid(valid_b), .is_inside(ins_b),
        .res_we(we_b), .res_addr(ra_b), .res_data(rdat_b), .busy(busy_b), .done(done_b),
        .timeout_err(terr_b), .proto_err(perr_b)
    );

    int errors = 0;
    int checks = 0;
    logic [30:0] pt_q [$];
    logic [31:0] res_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // point stream order, SEND run length and result writes of the 3-object build
    task automatic monitor();
        int run = 0;
        logic [30:0] p;
        logic [31:0] r;
        forever begin
            @(negedge clk);
            if (!reset) run = 0;
            else begin
                if (r_a != 0) begin
                    run++;
                    if (pt_q.size() == 0) chk("unexpected_point", 0, 1);
                    else begin
                        p = pt_q.pop_front();
                        chk("send_point", {1'b0, x_a, y_a, r_a}, {1'b0, p});
                    end
                end else if (run != 0) begin
                    chk("send_run_len", run, 6);
                    run = 0;
                end
                if (we_a) begin
                    if (res_q.size() == 0) chk("unexpected_write", 0, 1);
                    else begin
                        r = res_q.pop_front();
                        chk("result_write", 32'({ra_a, rdat_a}), r);
                    end
                end
            end
        end
    endtask

    task automatic push_pts(input int o);
        for (int k = 0; k < 6; k++) pt_q.push_back(mem_a[o*6+k]);
    endtask

    task automatic start_run();
        start_a = 1;
        tick();
        start_a = 0;
        chk("busy_after_start", busy_a, 1);
    endtask

    // entered in PRIME, leaves in WRITE; resp=0 lets the object time out
    task automatic frame(input int o, input int n, input logic ins, input logic resp);
        chk("prime_addr", addr_a, o*6);
        push_pts(o);
        tick();
        chk("load_addr", addr_a, o*6+1);
        tick(7);
        if (resp) begin
            tick(n-1);
            valid_a = 1;
            ins_a = ins;
            res_q.push_back(o*2 + ins);
            tick();
            valid_a = 0;
        end else begin
            res_q.push_back(o*2);
            tick(7);
            chk("no_early_timeout", we_a, 0);
            tick();
            chk("timeout_set", terr_a, 1);
        end
    endtask

    initial begin
        fork monitor(); join_none
        for (int i = 0; i < 18; i++) mem_a[i] = {10'(i*3+1), 10'(i*5+2), 11'(i+1)};
        mem_b[0] = {10'd10, 10'd20, 11'd5};
        mem_b[1] = {10'd30, 10'd20, 11'd5};
        mem_b[2] = {10'd40, 10'd40, 11'd5};
        mem_b[3] = {10'd30, 10'd60, 11'd5};
        mem_b[4] = {10'd10, 10'd60, 11'd5};
        mem_b[5] = {10'd0,  10'd40, 11'd5};
        #1 reset = 0;
        tick(2);
        chk("rst_busy", busy_a, 0);
        chk("rst_xyr", {1'b0, x_a, y_a, r_a}, 0);
        chk("rst_addr", addr_a, 0);
        chk("rst_flags", {we_a, ra_a, rdat_a, done_a, terr_a, perr_a}, 0);
        reset = 1;
        tick();

        // single-object build: exact cycle timing, start held high through DONE
        start_b = 1;
        chk("b_c0_idle", busy_b, 0);
        tick();
        chk("b_c1_busy", busy_b, 1);
        chk("b_c1_addr", addr_b, 0);
        chk("b_c1_x", x_b, 0);
        tick();
        chk("b_c2_addr", addr_b, 1);
        tick();
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("b_send_p%0d", k), {1'b0, x_b, y_b, r_b}, {1'b0, mem_b[k]});
            tick();
        end
        chk("b_c9_r", r_b, 0);
        tick(3);
        valid_b = 1;
        ins_b = 1;
        tick();
        valid_b = 0;
        chk("b_c13_we", we_b, 1);
        chk("b_c13_addr", ra_b, 0);
        chk("b_c13_data", rdat_b, 1);
        tick();
        chk("b_c14_done", done_b, 1);
        chk("b_c14_we", we_b, 0);
        tick();
        chk("b_c15_idle", busy_b, 0);
        tick();
        chk("b_restart", busy_b, 1);
        start_b = 0;

        // three objects answered inside, outside, inside
        start_run();
        for (int o = 0; o < 3; o++) begin
            frame(o, 4, 1'(o != 1), 1);
            chk("run1_no_timeout", terr_a, 0);
            tick();
        end
        chk("run1_done", done_a, 1);
        tick();
        chk("run1_idle", busy_a, 0);
        chk("run1_done_pulse", done_a, 0);
        chk("run1_perr", perr_a, 0);

        // receiver silent: every object times out
        start_run();
        for (int o = 0; o < 3; o++) begin
            frame(o, 0, 0, 0);
            tick();
        end
        tick();
        chk("timeout_sticky", terr_a, 1);

        // protocol error in SEND, ignored start, valid coinciding with timeout, reset mid-SEND
        start_run();
        chk("start_clears_timeout", terr_a, 0);
        push_pts(0);
        tick(5);
        valid_a = 1;
        ins_a = 0;
        tick();
        valid_a = 0;
        chk("proto_set", perr_a, 1);
        tick(5);
        valid_a = 1;
        ins_a = 1;
        res_q.push_back(1);
        tick();
        valid_a = 0;
        tick();
        chk("obj1_prime_addr", addr_a, 6);
        push_pts(1);
        tick(9);
        start_a = 1;
        tick();
        start_a = 0;
        tick(5);
        valid_a = 1;
        ins_a = 1;
        res_q.push_back(3);
        tick();
        valid_a = 0;
        chk("valid_beats_timeout_we", we_a, 1);
        chk("valid_beats_timeout_err", terr_a, 0);
        chk("proto_sticky", perr_a, 1);
        tick();
        chk("start_ignored_addr", addr_a, 12);
        pt_q.push_back(mem_a[12]);
        tick(3);
        chk("mid_send_addr", addr_a, 15);
        reset = 0;
        #1;
        chk("async_rst_x", x_a, 0);
        chk("async_rst_busy", busy_a, 0);
        chk("async_rst_we", we_a, 0);
        chk("async_rst_perr", perr_a, 0);
        chk("async_rst_addr", addr_a, 0);
        tick();
        chk("rst_hold_we", we_a, 0);
        reset = 1;
        tick(3);
        chk("post_rst_idle", busy_a, 0);
        chk("points_left", pt_q.size(), 0);
        chk("results_left", res_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
